// File: rtl/bcd_sub.sv
// bcd_sub: sequential 4-digit packed-BCD subtractor producing |a-b|.
//
// Digits are processed one per clock, least significant first. When the
// raw difference underflows (a<b) a second 4-cycle pass takes the 10's
// complement of the partial result in place, so d always ends up holding
// the magnitude and neg flags the sign. Invalid input digits (>9) skip
// the arithmetic and report err instead.
//
// Ports:
//   clk    - clock, rising edge active
//   rst_n  - asynchronous active-low reset
//   start  - request a-b; accepted only while idle
//   a, b   - minuend / subtrahend, 4 packed BCD digits, digit0 = [3:0]
//   d      - magnitude |a-b|, 4 packed BCD digits
//   neg    - 1 when a<b
//   err    - 1 when any latched input digit is >9
//   busy   - high while the SUB or NEG pass is running
//   done   - one-cycle completion pulse
module bcd_sub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] d,
  output logic        neg,
  output logic        err,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [1:0]  idx;
  logic        borrow;

  logic [3:0]        x;
  logic [3:0]        y;
  logic signed [4:0] t;
  logic              borrow_out;
  logic [3:0]        digit;
  logic              bad_in;

  function automatic logic has_bad_digit(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign bad_in = has_bad_digit(a) | has_bad_digit(b);

  // One shared digit subtractor: SUB computes a_i - b_i - borrow,
  // NEG computes 0 - d_i - borrow (10's complement of the partial result).
  always_comb begin
    x = '0;
    y = '0;
    case (state)
      SUB: begin
        x = a_q[{idx, 2'b00} +: 4];
        y = b_q[{idx, 2'b00} +: 4];
      end
      NEG: begin
        x = '0;
        y = d[{idx, 2'b00} +: 4];
      end
      default: ;
    endcase
    t = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, borrow});
    borrow_out = t[4];
    // For t in -10..-1 the low nibble is t+16, so adding 10 mod 16 gives t+10.
    digit = borrow_out ? (t[3:0] + 4'd10) : t[3:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = bad_in ? DONE : SUB;
      SUB:  if (idx == 2'd3) state_next = borrow_out ? NEG : DONE;
      NEG:  if (idx == 2'd3) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      d      <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
      idx    <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            d      <= '0;
            neg    <= 1'b0;
            err    <= bad_in;
            idx    <= '0;
            borrow <= 1'b0;
          end
        end
        SUB: begin
          d[{idx, 2'b00} +: 4] <= digit;
          idx                  <= idx + 2'd1;
          if (idx == 2'd3) begin
            // Final borrow out means a<b: start the complement pass clean.
            neg    <= borrow_out;
            borrow <= 1'b0;
          end else begin
            borrow <= borrow_out;
          end
        end
        NEG: begin
          d[{idx, 2'b00} +: 4] <= digit;
          idx                  <= idx + 2'd1;
          borrow               <= (idx == 2'd3) ? 1'b0 : borrow_out;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SUB) || (state == NEG);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_sub.sv
// tb_bcd_sub: self-checking bench for bcd_sub. Table-driven operations with
// a scoreboard queue, plus hand-written sequences for ignored starts and
// reset in the middle of the complement pass.
module tb_bcd_sub;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] d;
  logic        neg;
  logic        err;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  bcd_sub dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .d     (d),
    .neg   (neg),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        neg;
    logic        err;
    int          lat;   // rising edges after the accept edge until done is visible
    int          busyc; // cycles with busy high
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        neg;
    logic        err;
    int          lat;
    int          busyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Accept edge: drive at negedge, the following posedge is E0.
  task automatic issue(input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done (bounded), pops the scoreboard and compares.
  // If inj_at>0 a start with other operands is driven at that negedge index.
  task automatic finish_op(input string tag, input int inj_at);
    exp_t e;
    int   lat;
    int   bc;
    bit   seen;
    lat  = -1;
    bc   = 0;
    seen = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (busy) bc++;
      if (done) begin
        lat  = n - 1;
        seen = 1;
      end else if (n == inj_at) begin
        start = 1'b1;
        a     = 16'h9999;
        b     = 16'h0000;
      end
    end
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_busy_cycles"}, bc, e.busyc);
    check({tag, "_d"}, {16'h0, d}, {16'h0, e.d});
    check({tag, "_neg"}, {31'h0, neg}, {31'h0, e.neg});
    check({tag, "_err"}, {31'h0, err}, {31'h0, e.err});
    // One-cycle pulse, results held in IDLE.
    @(negedge clk);
    check({tag, "_done_pulse_len"}, {31'h0, done}, 32'd0);
    check({tag, "_hold_d"}, {16'h0, d}, {16'h0, e.d});
    check({tag, "_hold_neg"}, {31'h0, neg}, {31'h0, e.neg});
  endtask

  task automatic push_exp(input logic [15:0] ed, input logic en, input logic ee,
                          input int el, input int eb);
    exp_t e;
    e.d = ed; e.neg = en; e.err = ee; e.lat = el; e.busyc = eb;
    exp_q.push_back(e);
  endtask

  vec_t vecs[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    vecs.push_back('{16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 4, 4});
    vecs.push_back('{16'h0567, 16'h1234, 16'h0667, 1'b1, 1'b0, 8, 8});
    vecs.push_back('{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8, 8});
    vecs.push_back('{16'h9999, 16'h0001, 16'h9998, 1'b0, 1'b0, 4, 4});
    vecs.push_back('{16'h5000, 16'h5000, 16'h0000, 1'b0, 1'b0, 4, 4});
    vecs.push_back('{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0, 0});
    vecs.push_back('{16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, 8, 8});
    vecs.push_back('{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4, 4});
    vecs.push_back('{16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b1, 0, 0});

    #12;
    check("reset_d", {16'h0, d}, 32'h0);
    check("reset_flags", {28'h0, neg, err, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      push_exp(vecs[i].d, vecs[i].neg, vecs[i].err, vecs[i].lat, vecs[i].busyc);
      issue(vecs[i].a, vecs[i].b);
      finish_op($sformatf("vec%0d", i), 0);
    end

    // Start during SUB (negedge 2) and during DONE: both must be ignored.
    push_exp(16'h0667, 1'b0, 1'b0, 4, 4);
    issue(16'h1234, 16'h0567);
    finish_op("ign_sub", 2);
    // finish_op has consumed the DONE cycle; redo a DONE-time start by hand.
    push_exp(16'h0667, 1'b0, 1'b0, 4, 4);
    issue(16'h1234, 16'h0567);
    begin
      bit seen;
      seen = 0;
      for (int n = 1; n <= 20 && !seen; n++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      check("ign_done_seen", {31'h0, seen}, 32'd1);
      start = 1'b1;
      a     = 16'h0000;
      b     = 16'h9999;
      @(negedge clk);
      start = 1'b0;
      void'(exp_q.pop_front());
      check("ign_done_d", {16'h0, d}, 32'h0667);
      check("ign_done_neg", {31'h0, neg}, 32'd0);
      check("ign_done_busy", {31'h0, busy}, 32'd0);
      @(negedge clk);
      check("ign_done_still_idle", {30'h0, busy, done}, 32'd0);
    end

    // Reset in the 2nd NEG cycle (negedge 6 after accept).
    issue(16'h0567, 16'h1234);
    for (int n = 1; n <= 6; n++) @(negedge clk);
    check("pre_reset_busy", {31'h0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_d", {16'h0, d}, 32'h0);
    check("rst_mid_flags", {28'h0, neg, err, busy, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (done || busy) pulses++;
      end
      check("rst_no_done", pulses, 0);
    end
    push_exp(16'h0009, 1'b0, 1'b0, 4, 4);
    issue(16'h0010, 16'h0001);
    finish_op("after_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
